// File: rtl/can_header_decoder_pkg.sv
// Shared types and constants for the CAN header decoder slice.
`default_nettype none

package can_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    BASE_ID   = 3'd2,
    SRR_RTR   = 3'd3,
    IDE_BIT   = 3'd4,
    EXT_ID    = 3'd5,
    RTR_EXT   = 3'd6,
    EDL_BIT   = 3'd7
  } can_state_e;

  localparam int   CAN_BASE_ID_W = 11;
  localparam int   CAN_EXT_ID_W  = 18;
  localparam int   CAN_ID_W      = 29;
  localparam logic CAN_DOMINANT  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/can_header_decoder_if.sv
// Sample-point input and decoded-header output bundle of the CAN header decoder.
`default_nettype none

interface can_header_decoder_if;
  import can_pkg::*;

  logic                sp;
  logic                rx_bit;
  logic [CAN_ID_W-1:0] id;
  logic                ide;
  logic                rtr;
  logic                edl;
  logic                hdr_valid;
  logic                stuff_err;
  logic                busy;

  modport master (
    output sp, rx_bit,
    input  id, ide, rtr, edl, hdr_valid, stuff_err, busy
  );

  modport slave (
    input  sp, rx_bit,
    output id, ide, rtr, edl, hdr_valid, stuff_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/can_header_decoder_destuffer.sv
// CAN bit destuffer: drops stuff bits and flags a stuff-rule violation.
`default_nettype none

module can_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic sp_i,
  input  logic rx_bit_i,
  input  logic enable_i,
  input  logic restart_i,
  output logic data_strobe_o,
  output logic data_bit_o,
  output logic stuff_err_o
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;

  always_comb begin
    run_d         = run_q;
    last_d        = last_q;
    data_strobe_o = 1'b0;
    data_bit_o    = rx_bit_i;
    stuff_err_o   = 1'b0;
    if (sp_i) begin
      if (restart_i) begin
        // The SOF itself opens the first run.
        run_d  = RUN_W'(1);
        last_d = CAN_DOMINANT;
      end else if (enable_i) begin
        if (run_q == RUN_W'(STUFF_LEN)) begin
          if (rx_bit_i == last_q) begin
            stuff_err_o = 1'b1;
          end else begin
            run_d  = RUN_W'(1);
            last_d = rx_bit_i;
          end
        end else begin
          data_strobe_o = 1'b1;
          last_d        = rx_bit_i;
          run_d         = (rx_bit_i == last_q) ? run_q + RUN_W'(1) : RUN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/can_header_decoder.sv
// CAN header decoder: idle/SOF detection, destuffing and arbitration/control
// header extraction into held output registers.
`default_nettype none

module can_header_decoder
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_LEN = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  can_header_decoder_if.slave  bus
);

  localparam int IDLE_W = $clog2(IDLE_BITS + 1);

  can_state_e          state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [CAN_ID_W-1:0] shift_q, shift_d;
  logic                r12_q, r12_d;
  logic                ide_bit_q, ide_bit_d;

  logic [CAN_ID_W-1:0] id_q, id_d;
  logic                ide_q, ide_d;
  logic                rtr_q, rtr_d;
  logic                edl_q, edl_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic                stuff_err_q, stuff_err_d;
  logic                busy_q, busy_d;

  logic ds_strobe;
  logic ds_bit;
  logic ds_err;
  logic ds_enable;
  logic ds_restart;

  assign ds_restart = (state_q == IDLE) && (bus.rx_bit == CAN_DOMINANT);
  assign ds_enable  = (state_q != WAIT_IDLE) && (state_q != IDLE);

  can_destuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_destuffer (
    .clk           (clk),
    .reset         (reset),
    .sp_i          (bus.sp),
    .rx_bit_i      (bus.rx_bit),
    .enable_i      (ds_enable),
    .restart_i     (ds_restart),
    .data_strobe_o (ds_strobe),
    .data_bit_o    (ds_bit),
    .stuff_err_o   (ds_err)
  );

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    r12_d       = r12_q;
    ide_bit_d   = ide_bit_q;
    id_d        = id_q;
    ide_d       = ide_q;
    rtr_d       = rtr_q;
    edl_d       = edl_q;
    hdr_valid_d = 1'b0;
    stuff_err_d = 1'b0;
    busy_d      = busy_q;

    if (bus.sp) begin
      case (state_q)
        WAIT_IDLE: begin
          if (bus.rx_bit != CAN_DOMINANT) begin
            if (idle_cnt_q != IDLE_W'(IDLE_BITS)) begin
              idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
            if (idle_cnt_q >= IDLE_W'(IDLE_BITS - 1)) begin
              state_d    = IDLE;
              idle_cnt_d = '0;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end

        IDLE: begin
          if (bus.rx_bit == CAN_DOMINANT) begin
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            state_d   = BASE_ID;
          end
        end

        default: begin
          if (ds_err) begin
            stuff_err_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = WAIT_IDLE;
          end else if (ds_strobe) begin
            case (state_q)
              BASE_ID: begin
                shift_d   = {shift_q[CAN_ID_W-2:0], ds_bit};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'(CAN_BASE_ID_W - 1)) begin
                  state_d = SRR_RTR;
                end
              end
              SRR_RTR: begin
                r12_d   = ds_bit;
                state_d = IDE_BIT;
              end
              IDE_BIT: begin
                ide_bit_d = ds_bit;
                if (ds_bit) begin
                  bit_cnt_d = '0;
                  state_d   = EXT_ID;
                end else begin
                  state_d = EDL_BIT;
                end
              end
              EXT_ID: begin
                shift_d   = {shift_q[CAN_ID_W-2:0], ds_bit};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'(CAN_EXT_ID_W - 1)) begin
                  state_d = RTR_EXT;
                end
              end
              RTR_EXT: begin
                r12_d   = ds_bit;
                state_d = EDL_BIT;
              end
              EDL_BIT: begin
                // Base frames only ever shifted 11 bits; mask keeps id[28:11] clean regardless.
                id_d        = ide_bit_q ? shift_q
                                        : {{CAN_EXT_ID_W{1'b0}}, shift_q[CAN_BASE_ID_W-1:0]};
                ide_d       = ide_bit_q;
                rtr_d       = r12_q;
                edl_d       = ds_bit;
                hdr_valid_d = 1'b1;
                busy_d      = 1'b0;
                idle_cnt_d  = '0;
                state_d     = WAIT_IDLE;
              end
              default: begin
                state_d = WAIT_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      idle_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      r12_q       <= 1'b0;
      ide_bit_q   <= 1'b0;
      id_q        <= '0;
      ide_q       <= 1'b0;
      rtr_q       <= 1'b0;
      edl_q       <= 1'b0;
      hdr_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      r12_q       <= r12_d;
      ide_bit_q   <= ide_bit_d;
      id_q        <= id_d;
      ide_q       <= ide_d;
      rtr_q       <= rtr_d;
      edl_q       <= edl_d;
      hdr_valid_q <= hdr_valid_d;
      stuff_err_q <= stuff_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.id        = id_q;
  assign bus.ide       = ide_q;
  assign bus.rtr       = rtr_q;
  assign bus.edl       = edl_q;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.stuff_err = stuff_err_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/can_header_decoder.md
Name: can_header_decoder

Overview:
- Sits between the bit-timing/sample-point logic and the frame-type classification stage of the CAN decoder.
- Consumes raw sampled bus bits at each sample-point strobe and detects bus idle and SOF.
- Removes stuff bits and flags stuff errors.
- Extracts the arbitration/control header (identifier, RTR/RRS, IDE, EDL/FDF) and presents it as registered, held fields with a one-cycle valid pulse for the downstream frame-type and DLC stages.

Parameters:
- IDLE_BITS, 11, consecutive recessive samples required before an SOF is accepted.
- STUFF_LEN, 5, run length of equal bits after which the next bit is a stuff bit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sp  in  1  sample-point strobe, one clk cycle per CAN bit
- rx_bit  in  1  sampled bus level (0 = dominant, 1 = recessive), valid when sp=1
- id  out  29  identifier; base frames in id[10:0] with id[28:11]=0; extended frames as {ID_A, ID_B}
- ide  out  1  identifier-extension bit
- rtr  out  1  RTR (classical) / RRS (FD) bit of the frame's final arbitration position
- edl  out  1  EDL/FDF bit
- hdr_valid  out  1  one-clk pulse when id/ide/rtr/edl are updated
- stuff_err  out  1  one-clk pulse on stuff-rule violation
- busy  out  1  high from SOF until header done or error

Behaviour:
- All state advances only on clk edges where sp=1; with sp=0, internal state holds.
- reset has priority over sp.
- Reset values:
  - id=0, ide=0, rtr=0, edl=0, hdr_valid=0, stuff_err=0, busy=0.
  - FSM=WAIT_IDLE; idle counter, run counter, bit counter all 0.
- States and transitions:
  - WAIT_IDLE: count consecutive rx_bit=1 samples; a 0 clears the count. On the IDLE_BITS-th 1 → IDLE.
  - IDLE: rx_bit=0 → SOF. Set busy=1. Run counter=1, last=0, go to BASE_ID with bit counter=0. rx_bit=1 stays in IDLE.
  - BASE_ID: shift 11 data bits MSB first into the internal shift register → SRR_RTR.
  - SRR_RTR: capture bit as r12 → IDE_BIT.
  - IDE_BIT:
    - ide=0 → EDL_BIT.
    - ide=1 → EXT_ID, bit counter=0.
  - EXT_ID: shift 18 data bits → RTR_EXT.
  - RTR_EXT: capture bit as r12 → EDL_BIT.
  - EDL_BIT: capture FDF. In the same clk:
    - Load outputs: id, ide, rtr=r12, edl=bit.
    - Pulse hdr_valid, clear busy, → WAIT_IDLE.
    - WAIT_IDLE then absorbs the rest of the frame, EOF and IFS.
- Destuffing (active from SOF through EDL_BIT):
  - Track the last sampled level and a run counter.
  - When the run counter reaches STUFF_LEN, the next sample is a stuff bit:
    - Opposite level: discarded. No FSM/bit-counter advance; run counter=1, last=that level.
    - Equal level: pulse stuff_err, clear busy, → WAIT_IDLE. Outputs id/ide/rtr/edl keep their previous values; no hdr_valid.
  - Data bit equal to last: run counter+1. Different: run counter=1.
  - Stuff bits count toward runs; the SOF counts as the first bit of a run.
- Output holding:
  - id/ide/rtr/edl are registered and change only with hdr_valid (or reset).
  - They are stable for the downstream stage, which samples them on a later sample point.
- Reset mid-frame: returns to WAIT_IDLE with the reset values above. A new SOF requires IDLE_BITS recessive samples first.
- Counters:
  - Idle counter saturates; width is clog2(IDLE_BITS+1).
  - Bit counter is 5 bits and wraps never; it is cleared on each field entry.
- Simultaneous events:
  - A stuff violation on the EDL_BIT position yields stuff_err only, with no hdr_valid.
  - hdr_valid and stuff_err are never asserted in the same cycle.

Decomposition:
- Shared package can_pkg:
  - FSM state enum: WAIT_IDLE, IDLE, BASE_ID, SRR_RTR, IDE_BIT, EXT_ID, RTR_EXT, EDL_BIT.
  - Constants CAN_BASE_ID_W=11, CAN_EXT_ID_W=18, CAN_ID_W=29, CAN_DOMINANT=1'b0.
- One natural sub-module: can_destuffer.
  - Inputs: sp, rx_bit, enable/restart.
  - Outputs: data_strobe, data_bit, stuff_err.
  - The FSM consumes data_strobe instead of sp after SOF.

Test Plan:
- Base frame:
  - Stimulus: 11×1, SOF, ID 0x123, RTR=1, IDE=0, EDL=0 (no stuffing needed).
  - Response: hdr_valid pulse with id=0x123, ide=0, rtr=1, edl=0, busy falls the same clk. Downstream frame type = remote.
- Stuffed base frame:
  - Stimulus: 11×1, SOF, ID 0x000, RTR=0, IDE=0, EDL=1, with stuff bits inserted by the bench model after each 5 equal bits.
  - Response: id=0x000, rtr=0, edl=1, no stuff_err.
- Extended FD:
  - Stimulus: ID 0x12345678, SRR=1, IDE=1, RRS=0, FDF=1, stuffed by the bench model.
  - Response: id=0x12345678, ide=1, rtr=0, edl=1, single hdr_valid.
- Stuff error:
  - Stimulus: after idle, SOF followed by 5 more 0s (6 equal bits).
  - Response: stuff_err pulse on the 6th 0; no hdr_valid; outputs retain the previous header. A new frame is accepted only after 11×1.
- Reset mid-frame and idle gating:
  - Stimulus: assert reset during EXT_ID; then drive a 0 after only 10×1, followed by 1×1 and a valid frame.
  - Response: all outputs go to 0 after reset. The early 0 is not taken as SOF. The subsequent frame decodes correctly.
- sp gaps:
  - Stimulus: the same base frame as above, with sp held low for 3 clks between every bit.
  - Response: identical outputs; hdr_valid is exactly one clk wide.
